// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART receive path.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : payload bits per frame (8N1)
//   baud_div() : clocks per bit, rounded to nearest
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int DATA_BITS = 8;

   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- synchronous FIFO with a registered head output.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and data (ignored when full unless a pop
//                   happens in the same cycle)
//   pop           : remove the head entry (ignored when empty)
//   full          : all DEPTH entries occupied
//   dout, valid   : registered head entry and its occupancy flag
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_n;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_n;
   logic             do_push;
   logic             do_pop;

   assign full = (count == CW'(DEPTH));

   always_comb begin
      do_pop   = pop && (count != '0);
      do_push  = push && (!full || do_pop);
      rd_ptr_n = rd_ptr + AW'(do_pop);
      count_n  = count + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // The head register is refreshed from the next head slot every cycle; when
   // the FIFO is (or is about to be) empty the incoming word bypasses memory.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
         valid  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         valid  <= (count_n != '0);
         if (count_n != '0) dout <= (count == CW'(do_pop)) ? din : mem[rd_ptr_n];
      end
   end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend -- 8N1 serial receiver front end with valid/ready output.
//   clk        : system clock
//   RST        : asynchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   rx_data    : byte at head of the receive buffer
//   rx_valid   : rx_data holds an unread byte
//   rx_ready   : consumer takes rx_data when rx_valid && rx_ready
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, byte completed while the buffer was full
//   err_clr    : clears both sticky flags (a simultaneous set wins)
// Build option: define UART_RX_FIFO_EN to buffer FIFO_DEPTH bytes in
// uart_rx_fifo; otherwise a single holding register is used.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low, waiting for the line to return high
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 err_clr
);

   localparam int DIV = baud_div(CLK_HZ, BAUD);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2 - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   logic                 rx_meta;
   logic                 rxs;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bidx;
   logic [DATA_BITS-1:0] shreg;
   logic                 byte_done;
   logic                 pop;
   logic                 buf_full;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   assign byte_done = (state == STOP) && (cnt == CNT_LAST) && rxs;
   assign pop       = rx_valid && rx_ready;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         bidx      <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         if (err_clr) frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  cnt   <= '0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == CNT_MID) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     cnt   <= '0;
                     bidx  <= '0;
                     state <= DATA;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rxs, shreg[DATA_BITS-1:1]};
                  if (bidx == 3'(DATA_BITS - 1)) state <= STOP;
                  else                           bidx  <= bidx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            BREAK: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_RX_FIFO_EN
   logic fifo_full;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (RST),
      .push  (byte_done),
      .din   (shreg),
      .pop   (pop),
      .full  (fifo_full),
      .dout  (rx_data),
      .valid (rx_valid)
   );

   assign buf_full = fifo_full;
`else
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else if (byte_done && (!rx_valid || pop)) begin
         rx_data  <= shreg;
         rx_valid <= 1'b1;
      end else if (pop) begin
         rx_valid <= 1'b0;
      end
   end

   assign buf_full = rx_valid;
`endif

   // A pop in the same cycle frees the slot, so only an unpopped full buffer drops.
   always_ff @(posedge clk or posedge RST) begin
      if (RST)                                 overrun <= 1'b0;
      else if (byte_done && buf_full && !pop)  overrun <= 1'b1;
      else if (err_clr)                        overrun <= 1'b0;
   end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend -- scoreboard bench for uart_rx_frontend.
// Frames are driven bit-by-bit; expected bytes (with the cycle on which
// rx_valid should rise) are queued at send time and a negedge monitor pops
// and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

   localparam int CLK_HZ     = 50_000_000;
   localparam int BAUD       = 2_000_000;
   localparam int FIFO_DEPTH = 8;
   localparam int DIV        = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_RX_FIFO_EN
   localparam int EFF_DEPTH = FIFO_DEPTH;
`else
   localparam int EFF_DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       RST;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       err_clr;

   uart_rx_frontend #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      int         t;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   bit   rand_ready  = 1'b0;
   bit   exp_ferr    = 1'b0;
   bit   exp_ovr     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // Drives one frame. good=0 holds the stop bit low for low_bits bit times.
   // p_ready / p_clr raise rx_ready / err_clr for exactly the stop-sample edge.
   task automatic send_frame(input logic [7:0] b, input bit good, input int low_bits,
                             input bit p_ready, input bit p_clr);
      int   c0;
      int   ce;
      int   nstop;
      exp_t e;
      c0 = cyc;
      // Two synchroniser edges, one IDLE detection edge, half a bit to the
      // start-bit centre, then nine bit periods to the stop-bit centre.
      ce = c0 + 3 + DIV / 2 + 9 * DIV;
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(DIV);
      end
      if (good) begin
         if (exp_q.size() < EFF_DEPTH || p_ready) begin
            e.data = b;
            e.t    = ce;
            exp_q.push_back(e);
         end else begin
            exp_ovr = 1'b1;
         end
      end else begin
         exp_ferr = 1'b1;
      end
      rx    = good;
      nstop = good ? DIV : low_bits * DIV;
      for (int i = 0; i < nstop; i++) begin
         if (p_ready) rx_ready = (cyc == ce - 1);
         if (p_clr)   err_clr  = (cyc == ce - 1);
         tick(1);
      end
      rx = 1'b1;
      check("frame_err_after_frame", frame_err, exp_ferr);
      check("overrun_after_frame", overrun, exp_ovr);
      if (!good) tick(DIV);
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      tick(1);
      err_clr  = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      tick(1);
      check("frame_err_cleared", frame_err, 0);
      check("overrun_cleared", overrun, 0);
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         tick(1);
         n++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   // Monitor: compares every handshake and every rx_valid rise against the queue.
   initial begin
      bit         pv;
      bit         pr;
      logic [7:0] pd;
      pv = 1'b0;
      pr = 1'b0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (RST) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               check("hold_valid", rx_valid, 1);
               check("hold_data", rx_data, pd);
            end
            if (rx_valid && !pv) begin
               if (exp_q.size() == 0) check("spurious_valid", rx_valid, 0);
               else                   check("valid_rise_cycle", cyc, exp_q[0].t);
            end
            if (rx_valid && rx_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious_byte", rx_valid, 0);
               end else begin
                  check("rx_data", rx_data, exp_q[0].data);
                  void'(exp_q.pop_front());
               end
            end
            pv = rx_valid;
            pr = rx_ready;
            pd = rx_data;
         end
      end
   end

   initial begin
      #1_900_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b0;
      err_clr  = 1'b0;
      #200;
      check("reset_rx_data", rx_data, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_overrun", overrun, 0);
      @(posedge clk);
      #2;
      RST = 1'b0;
      rx_ready = 1'b1;
      tick(1000);
      check("idle_no_valid", rx_valid, 0);

      // single byte 0x30
      send_frame(8'h30, 1'b1, 0, 1'b0, 1'b0);
      wait_drain(50);

      // glitch shorter than half a bit
      rx = 1'b0;
      tick(DIV / 4);
      rx = 1'b1;
      tick(2 * DIV);
      check("glitch_no_valid", rx_valid, 0);
      check("glitch_no_frame_err", frame_err, 0);
      send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0);
      wait_drain(50);

      // framing error, recovery, clear
      send_frame(8'h55, 1'b0, 3, 1'b0, 1'b0);
      check("framing_no_push", rx_valid, 0);
      send_frame(8'h41, 1'b1, 0, 1'b0, 1'b0);
      wait_drain(50);
      clear_errors();

      // err_clr coinciding with a new framing error
      send_frame(8'h99, 1'b0, 1, 1'b0, 1'b1);
      clear_errors();

      // overrun with consumer stalled
      rx_ready = 1'b0;
      for (int i = 1; i <= EFF_DEPTH + 1; i++) send_frame(8'(i), 1'b1, 0, 1'b0, 1'b0);
      clear_errors();
      // full buffer with a pop on the same edge as the push: no overrun
      send_frame(8'hAA, 1'b1, 0, 1'b1, 1'b0);
      rx_ready = 1'b1;
      wait_drain(4 * EFF_DEPTH + 20);

      // reset during bit 4 of 0xA5 with a byte pending
      rx_ready = 1'b0;
      send_frame(8'h77, 1'b1, 0, 1'b0, 1'b0);
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 4; i++) begin
         rx = (i == 0 || i == 2);
         tick(DIV);
      end
      rx = 1'b0;
      tick(DIV / 2);
      #3;
      RST = 1'b1;
      #1;
      check("async_reset_valid", rx_valid, 0);
      check("async_reset_data", rx_data, 0);
      exp_q.delete();
      rx = 1'b1;
      tick(3);
      RST = 1'b0;
      rx_ready = 1'b1;
      tick(DIV);
      send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
      wait_drain(50);

      // randomized traffic, random consumer back-pressure
      rand_ready = 1'b1;
      repeat (40) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            rx = 1'b0;
            tick($urandom_range(1, DIV / 2 - 4));
            rx = 1'b1;
            tick(DIV);
         end else if (kind == 1) begin
            send_frame(8'($urandom_range(0, 255)), 1'b0, $urandom_range(1, 3), 1'b0, 1'b0);
            clear_errors();
         end else begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0, 1'b0);
         end
         tick($urandom_range(0, 2 * DIV));
      end
      rand_ready = 1'b0;
      rx_ready   = 1'b1;
      wait_drain(100);
      tick(5);
      check("final_rx_valid", rx_valid, 0);
      check("final_overrun", overrun, exp_ovr);
      check("final_frame_err", frame_err, exp_ferr);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end of the SoC UART: synchronises the asynchronous `rx` pin, detects start bits, samples 8N1 frames at mid-bit and hands completed bytes to the CPU-facing UART register block through a valid/ready handshake. It sits directly between the top-level `rx` pin and the UART data/status registers read by the 65C02. It provides optional byte buffering and sticky error flags.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency
- `BAUD`, 115200, line rate; bit period `DIV = (CLK_HZ + BAUD/2) / BAUD` = 434 clocks
- `FIFO_DEPTH`, 8, receive buffer entries (power of two, ≥2; used only with FIFO enabled)

- `clk`  in  1  system clock, all logic on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `rx_data`  out  8  received byte at head of buffer
- `rx_valid`  out  1  `rx_data` holds an unread byte
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`
- `frame_err`  out  1  sticky: stop bit sampled low
- `overrun`  out  1  sticky: byte completed with buffer full
- `err_clr`  in  1  one-cycle pulse clears both sticky flags

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1); all decisions use the synchronised `rxs`.
- Bit counter `cnt` counts 0..DIV-1; bit index `bidx` counts 0..7.
- FSM states:
  - IDLE: on `rxs` == 0, load `cnt` = 0, go START.
  - START: at `cnt` == DIV/2-1 (mid start bit): `rxs` == 1 → false start, back to IDLE; else reset `cnt`, `bidx` = 0, go DATA.
  - DATA: at each `cnt` == DIV-1, shift `rxs` into shift register MSB; the first bit received is the LSB. After `bidx` == 7, go STOP.
  - STOP: at `cnt` == DIV-1, sample the stop bit.
    - Stop bit high → push the byte and go IDLE.
    - Stop bit low → set `frame_err`, discard the byte, go BREAK.
  - BREAK: wait for `rxs` == 1, then go IDLE. This prevents a held-low line from retriggering.
- Push with buffer full, and no pop in the same cycle: byte dropped, `overrun` set, buffered contents unchanged.
- Push and pop in the same cycle with the buffer full: both occur, no overrun.
- `err_clr` in the same cycle as a new error: the set wins.
- Reset values: `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, FSM in IDLE, buffer empty.
- `RST` mid-frame aborts the frame immediately; the partial byte is lost.

## Timing
- The synchroniser adds 2 cycles from the `rx` pin edge to `rxs`.
- The start bit is confirmed DIV/2 cycles after `rxs` falls.
- Data bit n is sampled DIV/2 + (n+1)·DIV cycles after `rxs` falls; the stop bit at DIV/2 + 9·DIV.
- `rx_valid` rises the cycle after the stop-bit sample; `rx_data` is valid in the same cycle.
- `rx_valid` and `rx_data` are registered outputs. They are stable while `rx_valid && !rx_ready`.
- After a pop, the next entry appears on the following cycle with no bubble; `rx_valid` falls the following cycle if the buffer empties.
- Back-to-back frames (stop bit followed directly by start bit) are received without loss. IDLE is re-entered before the next falling edge.

## Configuration
- `UART_RX_FIFO_EN` defined: received bytes go into a FIFO of `FIFO_DEPTH` entries; overrun occurs only when all entries are occupied.
- Not defined: a single holding register is used (effective depth 1), `FIFO_DEPTH` is ignored, and overrun occurs when a second byte completes before the first is popped.
- Port list and handshake are identical in both builds.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, STOP, BREAK
  - constant function `baud_div(clk_hz, baud)`
  - `DATA_BITS` = 8
- One sub-module, `uart_rx_fifo`: synchronous FIFO with push/pop/full/empty and registered head output. It is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- Reset: hold `RST` for 200 ns with `rx` = 1 → all outputs at reset values, no `rx_valid` for 300 µs idle.
- Single byte: send start, bits 0,0,0,0,1,1,0,0 LSB-first, stop at 8681 ns/bit, with `rx_ready` = 1 → `rx_valid` pulses once with `rx_data` = 0x30, no flags set.
- Glitch: drive `rx` low for 2 µs (< half bit), then high → no byte, FSM back in IDLE, no `frame_err`.
- Framing: send 0x55 with the stop bit held low for 3 bit times → `frame_err` = 1, no push. The next valid frame 0x41 is received correctly. `err_clr` clears `frame_err`.
- Overrun: `rx_ready` = 0, send FIFO_DEPTH+1 bytes 0x01..0x09 (FIFO build) → `overrun` = 1. Popping yields 0x01..0x08 in order, and 0x09 is lost. In the non-FIFO build, the second byte sets `overrun` and the popped byte is 0x01.
- Mid-frame reset: assert `RST` during bit 4 of 0xA5, release, then send 0x3C → only 0x3C is delivered.
